vga_tile_compositor: RTL and testbench

//  Parametrised successor of the fixed 5-tile white renderer in the VGA top.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_tile_hit.sv | 38 +++
 rtl/vga_tile_compositor.sv | 133 +++++++++++++
 tb/tb_vga_tile_compositor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default beam/colour widths, the tile config record
// and the index-width helper used to size tile index ports.
package vga_pkg;

    localparam int unsigned X_W_DEF     = 11;
    localparam int unsigned Y_W_DEF     = 9;
    localparam int unsigned COLOR_W_DEF = 1;

    typedef struct packed {
        logic [X_W_DEF-1:0]       x;
        logic [Y_W_DEF-1:0]       y;
        logic [3*COLOR_W_DEF-1:0] color;
        logic                     en;
        logic                     blink;
    } tile_cfg_t;

    // clog2 with a floor of 1 so single-tile builds still get a real index port
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_tile_hit.sv
// Combinational rectangle test for one tile against the current beam position,
// including enable and blink gating.
module vga_tile_hit
    import vga_pkg::*;
#(
    parameter int unsigned X_W    = X_W_DEF,
    parameter int unsigned Y_W    = Y_W_DEF,
    parameter int unsigned TILE_W = 64,
    parameter int unsigned TILE_H = 32
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [X_W-1:0] tx,
    input  logic [Y_W-1:0] ty,
    input  logic           en,
    input  logic           blink,
    input  logic           blink_off,
    output logic           hit
);

    localparam logic [X_W:0] TILE_W_EXT = TILE_W[X_W:0];
    localparam logic [Y_W:0] TILE_H_EXT = TILE_H[Y_W:0];

    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;
    logic         in_x;
    logic         in_y;

    // One extra bit keeps the far edge from wrapping, so edge tiles clip
    always_comb begin
        x_end = {1'b0, tx} + TILE_W_EXT;
        y_end = {1'b0, ty} + TILE_H_EXT;
        in_x  = (x >= tx) && ({1'b0, x} < x_end);
        in_y  = (y >= ty) && ({1'b0, y} < y_end);
        hit   = en && !(blink && blink_off) && in_x && in_y;
    end

endmodule

// File: rtl/vga_tile_compositor.sv
// Fixed-priority compositor for N_TILES coloured rectangles with a double-buffered
// config bank swapped on frame_start and a 2-stage registered colour pipeline.
module vga_tile_compositor
    import vga_pkg::*;
#(
    parameter int unsigned  N_TILES   = 5,
    parameter int unsigned  X_W       = X_W_DEF,
    parameter int unsigned  Y_W       = Y_W_DEF,
    parameter int unsigned  COLOR_W   = COLOR_W_DEF,
    parameter int unsigned  TILE_W    = 64,
    parameter int unsigned  TILE_H    = 32,
    parameter int unsigned  BLINK_LOG = 5,
    localparam int unsigned IDX_W     = idx_w(N_TILES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_display,
    input  logic [X_W-1:0]       counter_x,
    input  logic [Y_W-1:0]       counter_y,
    input  logic                 frame_start,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [X_W-1:0]       cfg_x,
    input  logic [Y_W-1:0]       cfg_y,
    input  logic [3*COLOR_W-1:0] cfg_color,
    input  logic                 cfg_en,
    input  logic                 cfg_blink,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 hit_valid,
    output logic [IDX_W-1:0]     hit_idx
);

    typedef struct packed {
        logic [X_W-1:0]       x;
        logic [Y_W-1:0]       y;
        logic [3*COLOR_W-1:0] color;
        logic                 en;
        logic                 blink;
    } tile_t;

    tile_t                shadow [N_TILES];
    tile_t                active [N_TILES];
    logic [BLINK_LOG:0]   frame_cnt;
    logic                 blink_off;
    logic [N_TILES-1:0]   hit;
    logic [N_TILES-1:0]   hit_q;
    logic                 disp_q;
    logic                 win_any;
    logic [IDX_W-1:0]     win_idx;
    logic [3*COLOR_W-1:0] win_color;

    assign blink_off = frame_cnt[BLINK_LOG];

    // Non-blocking copy means a same-cycle write is seen by active only next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_TILES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            frame_cnt <= '0;
        end else begin
            if (frame_start) begin
                active    <= shadow;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (cfg_we && (32'(cfg_idx) < N_TILES)) begin
                shadow[cfg_idx] <= '{x: cfg_x, y: cfg_y, color: cfg_color,
                                     en: cfg_en, blink: cfg_blink};
            end
        end
    end

    for (genvar g = 0; g < N_TILES; g++) begin : g_hit
        vga_tile_hit #(
            .X_W    (X_W),
            .Y_W    (Y_W),
            .TILE_W (TILE_W),
            .TILE_H (TILE_H)
        ) u_hit (
            .x         (counter_x),
            .y         (counter_y),
            .tx        (active[g].x),
            .ty        (active[g].y),
            .en        (active[g].en),
            .blink     (active[g].blink),
            .blink_off (blink_off),
            .hit       (hit[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            disp_q <= 1'b0;
        end else begin
            hit_q  <= hit;
            disp_q <= in_display;
        end
    end

    always_comb begin
        win_any   = 1'b0;
        win_idx   = '0;
        win_color = '0;
        for (int unsigned i = 0; i < N_TILES; i++) begin
            if (hit_q[i] && !win_any) begin
                win_any   = 1'b1;
                win_idx   = IDX_W'(i);
                win_color = active[i].color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
        end else begin
            vga_r     <= win_color[3*COLOR_W-1 -: COLOR_W] & {COLOR_W{disp_q}};
            vga_g     <= win_color[2*COLOR_W-1 -: COLOR_W] & {COLOR_W{disp_q}};
            vga_b     <= win_color[COLOR_W-1 -: COLOR_W]   & {COLOR_W{disp_q}};
            hit_valid <= win_any & disp_q;
            hit_idx   <= win_idx;
        end
    end

endmodule

// File: tb/tb_vga_tile_compositor.sv
// Scoreboard bench for vga_tile_compositor: stimulus queues expected pixels two
// cycles ahead, a free-running monitor pops and compares them on their due cycle.
module tb_vga_tile_compositor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_display = 1'b0;
    logic [10:0] counter_x = '0;
    logic [8:0]  counter_y = '0;
    logic        frame_start = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [10:0] cfg_x = '0;
    logic [8:0]  cfg_y = '0;
    logic [2:0]  cfg_color = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_blink = 1'b0;
    logic [0:0]  vga_r, vga_g, vga_b;
    logic        hit_valid;
    logic [2:0]  hit_idx;

    vga_tile_compositor #(
        .N_TILES   (5),
        .BLINK_LOG (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_display  (in_display),
        .counter_x   (counter_x),
        .counter_y   (counter_y),
        .frame_start (frame_start),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_color   (cfg_color),
        .cfg_en      (cfg_en),
        .cfg_blink   (cfg_blink),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [2:0]  rgb;
        logic        v;
        logic [2:0]  idx;
        bit          chk_idx;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned fcnt = 0;

    always @(posedge clk) begin
        cyc++;
        #2;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.due != cyc || {vga_r, vga_g, vga_b} != mon_e.rgb ||
                hit_valid != mon_e.v || (mon_e.chk_idx && hit_idx != mon_e.idx)) begin
                errors++;
                $display("FAIL %s: got rgb=%b valid=%b idx=%0d cyc=%0d, want rgb=%b valid=%b idx=%0d cyc=%0d",
                         mon_e.name, {vga_r, vga_g, vga_b}, hit_valid, hit_idx, cyc,
                         mon_e.rgb, mon_e.v, mon_e.idx, mon_e.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic d, input logic [2:0] rgb,
                       input logic v, input logic [2:0] idx, input bit ci, input string name);
        counter_x  = 11'(x);
        counter_y  = 9'(y);
        in_display = d;
        sb.push_back('{due: cyc + 2, rgb: rgb, v: v, idx: idx, chk_idx: ci, name: name});
        tick();
    endtask

    task automatic miss(input int x, input int y, input string name);
        pix(x, y, 1'b1, 3'b000, 1'b0, 3'd0, 1'b1, name);
    endtask

    task automatic set_cfg(input int idx, input int x, input int y, input logic [2:0] c,
                           input logic en, input logic bl);
        cfg_idx   = 3'(idx);
        cfg_x     = 11'(x);
        cfg_y     = 9'(y);
        cfg_color = c;
        cfg_en    = en;
        cfg_blink = bl;
        cfg_we    = 1'b1;
    endtask

    task automatic write_tile(input int idx, input int x, input int y, input logic [2:0] c,
                              input logic en, input logic bl);
        set_cfg(idx, x, y, c, en, bl);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        fcnt++;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic vis;
        // reset
        tick();
        sb.push_back('{due: cyc + 1, rgb: 3'b000, v: 1'b0, idx: 3'd0, chk_idx: 1'b1, name: "reset_out"});
        tick();
        rst = 1'b0;
        drain();

        // 1: single tile, edges
        write_tile(0, 100, 50, 3'b100, 1'b1, 1'b0);
        miss(100, 50, "t1_before_frame");
        pulse();
        pix(100, 50, 1'b1, 3'b100, 1'b1, 3'd0, 1'b1, "t1_top_left");
        pix(163, 81, 1'b1, 3'b100, 1'b1, 3'd0, 1'b1, "t1_bottom_right");
        miss(164, 50, "t1_right_edge_out");
        miss(99, 50, "t1_left_out");
        miss(100, 82, "t1_bottom_out");
        miss(100, 49, "t1_top_out");

        // 2: overlap priority
        write_tile(1, 120, 60, 3'b010, 1'b1, 1'b0);
        pulse();
        pix(130, 70, 1'b1, 3'b100, 1'b1, 3'd0, 1'b1, "t2_overlap_low_wins");
        pix(170, 70, 1'b1, 3'b010, 1'b1, 3'd1, 1'b1, "t2_tile1_only");
        pix(183, 91, 1'b1, 3'b010, 1'b1, 3'd1, 1'b1, "t2_tile1_corner");
        miss(184, 70, "t2_tile1_right_out");

        // 3: double buffering
        write_tile(0, 300, 50, 3'b100, 1'b1, 1'b0);
        pix(100, 50, 1'b1, 3'b100, 1'b1, 3'd0, 1'b1, "t3_old_pos_held");
        miss(300, 50, "t3_new_pos_hidden");
        pulse();
        miss(100, 50, "t3_old_pos_gone");
        pix(300, 50, 1'b1, 3'b100, 1'b1, 3'd0, 1'b1, "t3_new_pos_live");
        set_cfg(0, 500, 50, 3'b100, 1'b1, 1'b0);
        frame_start = 1'b1;
        fcnt++;
        tick();
        frame_start = 1'b0;
        cfg_we = 1'b0;
        pix(300, 50, 1'b1, 3'b100, 1'b1, 3'd0, 1'b1, "t3_coincident_old_kept");
        miss(500, 50, "t3_coincident_not_live");
        pulse();
        pix(500, 50, 1'b1, 3'b100, 1'b1, 3'd0, 1'b1, "t3_coincident_live");
        miss(300, 50, "t3_coincident_old_gone");

        // 4: blink, half-period 2 frames
        write_tile(2, 400, 200, 3'b001, 1'b1, 1'b1);
        for (int f = 0; f < 6; f++) begin
            pulse();
            vis = ((fcnt >> 1) & 1) == 0;
            pix(410, 210, 1'b1, vis ? 3'b001 : 3'b000, vis, vis ? 3'd2 : 3'd0, 1'b1, "t4_blink");
        end

        // 5: right-edge clipping and display gating
        write_tile(3, 2040, 100, 3'b011, 1'b1, 1'b0);
        pulse();
        pix(2040, 100, 1'b1, 3'b011, 1'b1, 3'd3, 1'b1, "t5_edge_left");
        pix(2047, 131, 1'b1, 3'b011, 1'b1, 3'd3, 1'b1, "t5_edge_last");
        miss(0, 100, "t5_no_wrap_0");
        miss(55, 100, "t5_no_wrap_55");
        miss(2039, 100, "t5_before_edge");
        pix(2045, 100, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0, "t5_blanking");

        // out-of-range index is dropped
        write_tile(6, 700, 300, 3'b111, 1'b1, 1'b0);
        pulse();
        miss(710, 310, "bad_idx_ignored");
        pix(170, 70, 1'b1, 3'b010, 1'b1, 3'd1, 1'b1, "bad_idx_tile1_intact");

        // 6: reset mid-line
        pix(510, 60, 1'b1, 3'b100, 1'b1, 3'd0, 1'b1, "t6_before_rst");
        drain();
        rst = 1'b1;
        sb.push_back('{due: cyc + 1, rgb: 3'b000, v: 1'b0, idx: 3'd0, chk_idx: 1'b1, name: "t6_rst_next_cycle"});
        tick();
        rst = 1'b0;
        fcnt = 0;
        drain();
        miss(510, 60, "t6_blank_after_rst");
        pulse();
        miss(510, 60, "t6_blank_after_frame");
        write_tile(0, 500, 50, 3'b100, 1'b1, 1'b0);
        pulse();
        pix(510, 60, 1'b1, 3'b100, 1'b1, 3'd0, 1'b1, "t6_reprogrammed");

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
